// File: rtl/lcd_refresh_sched_pkg.sv
// lcd_refresh_sched_pkg: shared FSM states, LCD command words and default sequence sizing
package lcd_refresh_sched_pkg;
  localparam int          DEF_INIT_LEN  = 5;
  localparam int          DEF_FRAME_LEN = 38;
  localparam logic [17:0] DEF_DLY_CMD   = 18'h3FFFE;
  localparam logic [17:0] DEF_DLY_CLR   = 18'h3FFFF;
  localparam logic [19:0] DEF_TIMEOUT   = 20'hFFFFF;
  localparam logic [8:0]  LCD_CMD_CLEAR = 9'h001;
  localparam logic [8:0]  LCD_CMD_LINE2 = 9'h0C0;
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_LATCH,
    ST_START,
    ST_WAIT_DONE,
    ST_DELAY,
    ST_NEXT
  } state_e;
  function automatic logic [19:0] settle_cycles(logic [8:0] word, logic [17:0] dly_cmd, logic [17:0] dly_clr);
    return 20'(word == LCD_CMD_CLEAR ? dly_clr : dly_cmd);
  endfunction
endpackage

// File: rtl/lcd_refresh_sched_if.sv
// lcd_refresh_sched_if: character-source and LCD-controller handshake bundle
interface lcd_refresh_sched_if;
  logic [5:0] char_idx;
  logic [8:0] char_data;
  logic [7:0] lcd_data;
  logic       lcd_rs;
  logic       lcd_start;
  logic       lcd_done;
  modport master (output char_idx, lcd_data, lcd_rs, lcd_start, input char_data, lcd_done);
  modport slave  (input char_idx, lcd_data, lcd_rs, lcd_start, output char_data, lcd_done);
endinterface

// File: rtl/lcd_refresh_sched_delay_timer.sv
// lcd_delay_timer: after a load counts 1..limit and pulses expired on the final count
module lcd_delay_timer #(
  parameter int W = 20
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic [W-1:0] limit_i,
  output logic         expired_o
);
  logic [W-1:0] cnt_q, cnt_d, lim_q, lim_d;
  logic         run_q, run_d, hit;
  assign hit       = run_q && cnt_q == lim_q;
  assign expired_o = hit;
  always_comb begin
    cnt_d = load_i ? W'(1) : (run_q && !hit) ? cnt_q + 1'b1 : cnt_q;
    lim_d = load_i ? limit_i : lim_q;
    run_d = load_i | (run_q & ~hit);
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      cnt_q <= '0;
      lim_q <= '0;
      run_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      lim_q <= lim_d;
      run_q <= run_d;
    end
endmodule

// File: rtl/lcd_refresh_sched.sv
// lcd_refresh_sched: sequences LUT words into the LCD controller with settle delays and refresh coalescing
module lcd_refresh_sched
  import lcd_refresh_sched_pkg::*;
#(
  parameter int          INIT_LEN  = DEF_INIT_LEN,
  parameter int          FRAME_LEN = DEF_FRAME_LEN,
  parameter logic [17:0] DLY_CMD   = DEF_DLY_CMD,
  parameter logic [17:0] DLY_CLR   = DEF_DLY_CLR,
  parameter logic [19:0] TIMEOUT   = DEF_TIMEOUT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] screen_id_i,
  input  logic       dirty_i,
  lcd_refresh_sched_if.master bus,
  output logic       busy_o,
  output logic       frame_done_o,
  output logic       err_o
);
  state_e      state_q, state_d;
  logic [5:0]  idx_q, idx_d;
  logic [7:0]  data_q, data_d;
  logic [2:0]  screen_q;
  logic        full_q, full_d, pending_q, pending_d, err_q, err_d, rs_q, rs_d;
  logic        req, last, tmr_load, tmr_exp;
  logic [19:0] tmr_val;
  lcd_delay_timer #(.W(20)) u_tmr (
    .clk      (clk),
    .rst      (rst),
    .load_i   (tmr_load),
    .limit_i  (tmr_val),
    .expired_o(tmr_exp)
  );
  assign req  = (screen_id_i != screen_q) | dirty_i;
  assign last = idx_q == 6'(FRAME_LEN - 1);
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    full_d    = full_q;
    pending_d = pending_q;
    err_d     = err_q;
    rs_d      = rs_q;
    data_d    = data_q;
    tmr_load  = 1'b0;
    tmr_val   = TIMEOUT;
    case (state_q)
      ST_IDLE: if (pending_q) begin
        pending_d = 1'b0;
        idx_d     = full_q ? 6'd0 : 6'(INIT_LEN - 1);
        full_d    = 1'b0;
        state_d   = ST_FETCH;
      end
      ST_FETCH: state_d = ST_LATCH;
      ST_LATCH: begin
        {rs_d, data_d} = bus.char_data;
        state_d        = ST_START;
      end
      ST_START: begin
        tmr_load = 1'b1;
        state_d  = ST_WAIT_DONE;
      end
      ST_WAIT_DONE: if (bus.lcd_done || tmr_exp) begin
        err_d    = err_q | ~bus.lcd_done;
        tmr_load = 1'b1;
        tmr_val  = settle_cycles({rs_q, data_q}, DLY_CMD, DLY_CLR);
        state_d  = ST_DELAY;
      end
      ST_DELAY: state_d = tmr_exp ? ST_NEXT : ST_DELAY;
      ST_NEXT: begin
        idx_d   = last ? idx_q : idx_q + 1'b1;
        state_d = last ? ST_IDLE : ST_FETCH;
      end
      default: state_d = ST_IDLE;
    endcase
    pending_d = req | pending_d;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q   <= ST_IDLE;
      idx_q     <= '0;
      full_q    <= 1'b1;
      pending_q <= 1'b1;
      err_q     <= 1'b0;
      rs_q      <= 1'b0;
      data_q    <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      full_q    <= full_d;
      pending_q <= pending_d;
      err_q     <= err_d;
      rs_q      <= rs_d;
      data_q    <= data_d;
    end
  always_ff @(posedge clk or posedge rst)
    if (rst) screen_q <= screen_id_i;
    else screen_q <= screen_id_i;
  assign bus.char_idx  = idx_q;
  assign bus.lcd_data  = data_q;
  assign bus.lcd_rs    = rs_q;
  assign bus.lcd_start = state_q == ST_START || state_q == ST_WAIT_DONE;
  assign busy_o        = state_q != ST_IDLE;
  assign frame_done_o  = state_q == ST_NEXT && last;
  assign err_o         = err_q;
endmodule
